// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode microSD card responder with CMD17 block reads
//
// Ports:
//   control_clk_i  system clock; SCK is oversampled, its period must be >= 8 clocks
//   control_rst_i  asynchronous active-high reset
//   SCK, SS, MOSI  SPI mode 0 inputs from the master (SS active low, MSB first)
//   MISO           serial data to the master, MSB first
//   mem_addr_o     byte address into the card image
//   mem_re_o       one-cycle image read strobe
//   mem_data_i     image byte, valid the cycle after mem_re_o
//   idle_o         card idle-state flag (R1 bit 0)
//   cmd_valid_o    one-cycle pulse per decoded command frame
//   cmd_index_o    index of the last decoded command

module sd_spi_responder #(
  parameter int NCR_BYTES   = 1,
  parameter int NAC_BYTES   = 2,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        control_clk_i,
  input  logic        control_rst_i,
  input  logic        SCK,
  input  logic        SS,
  input  logic        MOSI,
  output logic        MISO,
  output logic [31:0] mem_addr_o,
  output logic        mem_re_o,
  input  logic [7:0]  mem_data_i,
  output logic        idle_o,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o
);

  typedef enum logic [2:0] {
    S_HUNT, S_CMD, S_NCR, S_RESP, S_NAC, S_TOKEN, S_DATA, S_CRC
  } state_t;

  state_t      state_q, state_d;
  logic        sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
  logic        ss_meta_q, ss_meta_d, ss_sync_q, ss_sync_d;
  logic        mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [39:0] resp_q, resp_d;
  logic        resp_r7_q, resp_r7_d;
  logic        read_q, read_d;
  logic        idle_q, idle_d;
  logic        app_q, app_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] addr_q, addr_d;
  logic        re_q, re_d;
  logic        re_dly_q, re_dly_d;
  logic [7:0]  pre_q, pre_d;

  logic        sck_rise, sck_fall;
  logic [7:0]  rx_byte;
  logic [7:0]  next_byte;
  logic [7:0]  r1;
  logic        r7;

  always_comb begin
    sck_meta_d  = SCK;
    sck_sync_d  = sck_meta_q;
    sck_prev_d  = sck_sync_q;
    ss_meta_d   = SS;
    ss_sync_d   = ss_meta_q;
    mosi_meta_d = MOSI;
    mosi_sync_d = mosi_meta_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    resp_d      = resp_q;
    resp_r7_d   = resp_r7_q;
    read_d      = read_q;
    idle_d      = idle_q;
    app_d       = app_q;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;
    addr_d      = addr_q;
    re_d        = 1'b0;
    re_dly_d    = re_q;
    // Image data arrives the cycle after the strobe; grab it one cycle later still.
    pre_d       = re_dly_q ? mem_data_i : pre_q;
    sck_rise    = sck_sync_q & ~sck_prev_q;
    sck_fall    = ~sck_sync_q & sck_prev_q;
    rx_byte     = {rx_q, mosi_sync_q};
    next_byte   = 8'hFF;
    r1          = 8'hFF;
    r7          = 1'b0;

    if (ss_sync_q) begin
      // Deselected: abandon any transfer, card state (idle/app) is kept.
      state_d    = S_HUNT;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 32'd0;
      rx_d       = 7'd0;
      tx_d       = 8'hFF;
      miso_d     = 1'b1;
    end else if (sck_rise) begin
      rx_d      = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_cnt_d = byte_cnt_q + 32'd1;
        case (state_q)
          S_HUNT: begin
            byte_cnt_d = 32'd0;
            if (rx_byte[7:6] == 2'b01) begin
              idx_d   = rx_byte[5:0];
              state_d = S_CMD;
            end
          end
          S_CMD: begin
            if (byte_cnt_q < 32'd4) begin
              arg_d = {arg_q[23:0], rx_byte};
            end else begin
              byte_cnt_d = 32'd0;
              if (!rx_byte[0]) begin
                state_d = S_HUNT;
              end else begin
                cmd_valid_d = 1'b1;
                cmd_index_d = idx_q;
                app_d       = 1'b0;
                read_d      = 1'b0;
                case (idx_q)
                  6'd0: begin
                    idle_d = 1'b1;
                    r1     = 8'h01;
                  end
                  6'd8: begin
                    r1 = {7'd0, idle_q};
                    r7 = 1'b1;
                  end
                  6'd55: begin
                    app_d = 1'b1;
                    r1    = {7'd0, idle_q};
                  end
                  6'd41: begin
                    if (app_q) begin
                      idle_d = 1'b0;
                      r1     = 8'h00;
                    end else begin
                      r1 = {5'd0, 1'b1, 1'b0, idle_q};
                    end
                  end
                  6'd16: r1 = {7'd0, idle_q};
                  6'd17: begin
                    if (!idle_q) begin
                      r1     = 8'h00;
                      read_d = 1'b1;
                    end else begin
                      r1 = 8'h05;
                    end
                  end
                  default: r1 = {5'd0, 1'b1, 1'b0, idle_q};
                endcase
                resp_d    = {r1, 8'h00, 8'h00, 4'h0, arg_q[11:8], arg_q[7:0]};
                resp_r7_d = r7;
                state_d   = S_NCR;
              end
            end
          end
          S_NCR: begin
            if (byte_cnt_q == 32'(NCR_BYTES - 1)) begin
              next_byte  = resp_q[39:32];
              resp_d     = {resp_q[31:0], 8'hFF};
              state_d    = S_RESP;
              byte_cnt_d = 32'd0;
            end
          end
          S_RESP: begin
            if (byte_cnt_q == (resp_r7_q ? 32'd4 : 32'd0)) begin
              byte_cnt_d = 32'd0;
              if (!read_q) begin
                state_d = S_HUNT;
              end else if (NAC_BYTES == 0) begin
                // Token goes out next, so byte 0 is fetched right now.
                next_byte = 8'hFE;
                state_d   = S_TOKEN;
                addr_d    = arg_q * 32'(BLOCK_BYTES);
                re_d      = 1'b1;
              end else begin
                state_d = S_NAC;
              end
            end else begin
              next_byte = resp_q[39:32];
              resp_d    = {resp_q[31:0], 8'hFF};
            end
          end
          S_NAC: begin
            if (byte_cnt_q == 32'(NAC_BYTES - 1)) begin
              next_byte  = 8'hFE;
              state_d    = S_TOKEN;
              byte_cnt_d = 32'd0;
              addr_d     = arg_q * 32'(BLOCK_BYTES);
              re_d       = 1'b1;
            end
          end
          S_TOKEN: begin
            next_byte  = pre_q;
            state_d    = S_DATA;
            byte_cnt_d = 32'd0;
            if (BLOCK_BYTES > 1) begin
              addr_d = addr_q + 32'd1;
              re_d   = 1'b1;
            end
          end
          S_DATA: begin
            // byte_cnt_q is the index of the data byte that just finished.
            if (byte_cnt_q == 32'(BLOCK_BYTES - 1)) begin
              state_d    = S_CRC;
              byte_cnt_d = 32'd0;
            end else begin
              next_byte = pre_q;
              if (byte_cnt_q + 32'd2 < 32'(BLOCK_BYTES)) begin
                addr_d = addr_q + 32'd1;
                re_d   = 1'b1;
              end
            end
          end
          S_CRC: begin
            if (byte_cnt_q == 32'd1) begin
              state_d    = S_HUNT;
              byte_cnt_d = 32'd0;
            end
          end
          default: begin
            state_d    = S_HUNT;
            byte_cnt_d = 32'd0;
          end
        endcase
        // The next byte's MSB is presented as soon as the current byte completes.
        miso_d = next_byte[7];
        tx_d   = {next_byte[6:0], 1'b1};
      end
    end else if (sck_fall && bit_cnt_q != 3'd0) begin
      // The fall right after a byte boundary keeps the MSB already presented.
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b1};
    end
  end

  always_ff @(posedge control_clk_i or posedge control_rst_i) begin
    if (control_rst_i) begin
      state_q     <= S_HUNT;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b1;
      mosi_sync_q <= 1'b1;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 32'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'hFF;
      miso_q      <= 1'b1;
      idx_q       <= 6'd0;
      arg_q       <= 32'd0;
      resp_q      <= 40'hFF_FFFF_FFFF;
      resp_r7_q   <= 1'b0;
      read_q      <= 1'b0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= 6'd0;
      addr_q      <= 32'd0;
      re_q        <= 1'b0;
      re_dly_q    <= 1'b0;
      pre_q       <= 8'hFF;
    end else begin
      state_q     <= state_d;
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_meta_q   <= ss_meta_d;
      ss_sync_q   <= ss_sync_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      resp_q      <= resp_d;
      resp_r7_q   <= resp_r7_d;
      read_q      <= read_d;
      idle_q      <= idle_d;
      app_q       <= app_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      addr_q      <= addr_d;
      re_q        <= re_d;
      re_dly_q    <= re_dly_d;
      pre_q       <= pre_d;
    end
  end

  assign MISO        = miso_q;
  assign mem_addr_o  = addr_q;
  assign mem_re_o    = re_q;
  assign idle_o      = idle_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_index_o = cmd_index_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - self-checking bench for sd_spi_responder

module tb_sd_spi_responder;

  localparam int NCR = 1;
  localparam int NAC = 2;
  localparam int BLK = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b1;
  logic [7:0]  mem_data_i = 8'h00;
  logic        MISO;
  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic        idle_o;
  logic        cmd_valid_o;
  logic [5:0]  cmd_index_o;

  always #5 clk = ~clk;

  sd_spi_responder #(
    .NCR_BYTES(NCR),
    .NAC_BYTES(NAC),
    .BLOCK_BYTES(BLK)
  ) dut (
    .control_clk_i(clk),
    .control_rst_i(rst),
    .SCK(sck),
    .SS(ss),
    .MOSI(mosi),
    .MISO(MISO),
    .mem_addr_o(mem_addr_o),
    .mem_re_o(mem_re_o),
    .mem_data_i(mem_data_i),
    .idle_o(idle_o),
    .cmd_valid_o(cmd_valid_o),
    .cmd_index_o(cmd_index_o)
  );

  // Card image: byte[a] = a[7:0], registered read.
  always @(posedge clk) if (mem_re_o) mem_data_i <= mem_addr_o[7:0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-level card model: a queue of bytes the card owes the master.
  bit          m_idle = 1'b1;
  bit          m_app = 1'b0;
  int          m_cnt = 0;
  logic [7:0]  m_frame [0:5];
  logic [7:0]  m_out [$];
  logic [5:0]  exp_idx [$];
  logic [31:0] exp_addr [$];

  task automatic model_reset();
    m_idle = 1'b1;
    m_app  = 1'b0;
    m_cnt  = 0;
    m_out.delete();
    exp_idx.delete();
    exp_addr.delete();
  endtask

  task automatic model_cmd();
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [31:0] a;
    bit          was_app;
    if (m_frame[5][0] == 1'b0) return;
    idx = m_frame[0][5:0];
    arg = {m_frame[1], m_frame[2], m_frame[3], m_frame[4]};
    exp_idx.push_back(idx);
    for (int k = 0; k < NCR; k++) m_out.push_back(8'hFF);
    was_app = m_app;
    m_app = (idx == 6'd55);
    case (idx)
      6'd0: begin m_idle = 1'b1; m_out.push_back(8'h01); end
      6'd8: begin
        m_out.push_back({7'd0, m_idle});
        m_out.push_back(8'h00);
        m_out.push_back(8'h00);
        m_out.push_back({4'h0, arg[11:8]});
        m_out.push_back(arg[7:0]);
      end
      6'd55, 6'd16: m_out.push_back({7'd0, m_idle});
      6'd41: begin
        if (was_app) begin m_idle = 1'b0; m_out.push_back(8'h00); end
        else m_out.push_back(8'h04 | {7'd0, m_idle});
      end
      6'd17: begin
        if (m_idle) m_out.push_back(8'h05);
        else begin
          m_out.push_back(8'h00);
          for (int k = 0; k < NAC; k++) m_out.push_back(8'hFF);
          m_out.push_back(8'hFE);
          for (int i = 0; i < BLK; i++) begin
            a = arg * BLK + i;
            m_out.push_back(a[7:0]);
            exp_addr.push_back(a);
          end
          m_out.push_back(8'hFF);
          m_out.push_back(8'hFF);
        end
      end
      default: m_out.push_back(8'h04 | {7'd0, m_idle});
    endcase
  endtask

  task automatic model_byte(input logic [7:0] rx, output logic [7:0] e);
    if (m_out.size() != 0) begin
      e = m_out.pop_front();
    end else begin
      e = 8'hFF;
      if (m_cnt == 0) begin
        if (rx[7:6] == 2'b01) begin m_frame[0] = rx; m_cnt = 1; end
      end else begin
        m_frame[m_cnt] = rx;
        m_cnt++;
        if (m_cnt == 6) begin m_cnt = 0; model_cmd(); end
      end
    end
  endtask

  // Full-duplex byte exchange, SCK period 8 clocks, MISO sampled before each rise.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic [7:0] e;
    model_byte(tx, e);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = MISO;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    check("miso_vs_model", 32'(rx), 32'(e));
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic [7:0] r;
    for (int k = 0; k < 6; k++) xfer(f[47-8*k -: 8], r);
  endtask

  task automatic expect_byte(input string name, input logic [7:0] want);
    logic [7:0] r;
    xfer(8'hFF, r);
    check(name, 32'(r), 32'(want));
  endtask

  task automatic filler(input int n);
    logic [7:0] r;
    for (int k = 0; k < n; k++) xfer(8'hFF, r);
  endtask

  // Per-cycle compare of the strobed outputs against the model's queues.
  logic [5:0]  ei;
  logic [31:0] ea;
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid_o) begin
        if (exp_idx.size() == 0) check("cmd_valid_unexpected", 32'(cmd_valid_o), 32'd0);
        else begin ei = exp_idx.pop_front(); check("cmd_index", 32'(cmd_index_o), 32'(ei)); end
      end
      if (mem_re_o) begin
        if (exp_addr.size() == 0) check("mem_re_unexpected", 32'(mem_re_o), 32'd0);
        else begin ea = exp_addr.pop_front(); check("mem_addr", mem_addr_o, ea); end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(MISO), 32'd1);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_re", 32'(mem_re_o), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_cmd_index", 32'(cmd_index_o), 32'd0);
    check("rst_idle", 32'(idle_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(48'h40_00000000_95);
    expect_byte("cmd0_ncr", 8'hFF);
    expect_byte("cmd0_r1", 8'h01);
    check("cmd0_index", 32'(cmd_index_o), 32'd0);

    send_frame(48'h48_000001AA_87);
    expect_byte("cmd8_ncr", 8'hFF);
    expect_byte("cmd8_r1", 8'h01);
    expect_byte("cmd8_b1", 8'h00);
    expect_byte("cmd8_b2", 8'h00);
    expect_byte("cmd8_b3", 8'h01);
    expect_byte("cmd8_b4", 8'hAA);
    check("cmd8_index", 32'(cmd_index_o), 32'd8);

    send_frame(48'h51_00000000_55);
    expect_byte("cmd17_idle_ncr", 8'hFF);
    expect_byte("cmd17_idle_r1", 8'h05);
    for (int k = 0; k < 3; k++) expect_byte("cmd17_idle_nodata", 8'hFF);

    send_frame(48'h77_00000000_65);
    expect_byte("cmd55_ncr", 8'hFF);
    expect_byte("cmd55_r1", 8'h01);
    send_frame(48'h69_40000000_77);
    expect_byte("acmd41_ncr", 8'hFF);
    expect_byte("acmd41_r1", 8'h00);
    check("init_idle", 32'(idle_o), 32'd0);

    send_frame(48'h69_00000000_E5);
    expect_byte("cmd41_noapp_ncr", 8'hFF);
    expect_byte("cmd41_noapp_r1", 8'h04);

    send_frame(48'h40_00000000_94);
    for (int k = 0; k < 3; k++) expect_byte("stop0_silent", 8'hFF);
    check("stop0_index_kept", 32'(cmd_index_o), 32'd41);
    check("stop0_idle_kept", 32'(idle_o), 32'd0);

    send_frame(48'h51_00000002_FF);
    expect_byte("rd_ncr", 8'hFF);
    expect_byte("rd_r1", 8'h00);
    expect_byte("rd_nac0", 8'hFF);
    expect_byte("rd_nac1", 8'hFF);
    expect_byte("rd_token", 8'hFE);
    for (int i = 0; i < BLK; i++) expect_byte("rd_data", i[7:0]);
    expect_byte("rd_crc0", 8'hFF);
    expect_byte("rd_crc1", 8'hFF);
    check("rd_last_addr", mem_addr_o, 32'd1535);

    // Reset pulse in the middle of a data block, SS held low throughout.
    send_frame(48'h51_00000003_FF);
    filler(25);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_miso", 32'(MISO), 32'd1);
    check("midrst_idle", 32'(idle_o), 32'd1);
    check("midrst_mem_re", 32'(mem_re_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(48'h40_00000000_95);
    expect_byte("postrst_cmd0_ncr", 8'hFF);
    expect_byte("postrst_cmd0_r1", 8'h01);

    send_frame(48'h77_00000000_65);
    filler(2);
    send_frame(48'h69_40000000_77);
    filler(2);
    check("reinit_idle", 32'(idle_o), 32'd0);

    // SS raised after data byte 100 of a block read.
    send_frame(48'h51_00000002_FF);
    filler(5 + 101);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    m_out.delete();
    m_cnt = 0;
    exp_addr.delete();
    check("ssabort_miso", 32'(MISO), 32'd1);
    check("ssabort_idle_kept", 32'(idle_o), 32'd0);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(48'h40_00000000_95);
    expect_byte("ssabort_cmd0_ncr", 8'hFF);
    expect_byte("ssabort_cmd0_r1", 8'h01);
    check("ssabort_cmd0_idle", 32'(idle_o), 32'd1);

    repeat (8) @(negedge clk);
    check("cmd_pulses_all_seen", 32'(exp_idx.size()), 32'd0);
    check("mem_reads_all_seen", 32'(exp_addr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
